ped_xing_ctrl: RTL
==================

# ped_xing_ctrl

Multi-channel pedestrian crossing controller, parametrised successor of the single-crossing pedestrian phase block. It sits beside the vehicle traffic FSM. Per channel, the FSM issues a start, then the block runs an optional safety delay, a steady green, a blinking green and a hand-back pulse. It adds a maintenance mode that darkens all pedestrian heads, and a shared seconds prescaler.

## Interface
- TICKS_PER_SEC, 10000000, clk cycles per second; even, >= 2
- N_CH, 2, number of independent crossings; 1..8
- DELAY_S, 1, red-hold seconds between start and green; 0 skips the delay
- GREEN_S, 12, steady green seconds; >= 1
- BLINK_S, 6, blinking green seconds; >= 1
- CW, 8, phase counter width; must hold max(DELAY_S, GREEN_S, BLINK_S)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low
- maint_i  in  1  maintenance; level; overrides all channels
- start_i  in  N_CH  per-channel start request; synchronous pulse or level
- busy_o  out  N_CH  channel not in IDLE or MAINT
- done_o  out  N_CH  one-cycle hand-back pulse per channel
- green_o  out  N_CH  pedestrian green lamp
- red_o  out  N_CH  pedestrian red lamp

## Operation
- Reset values: all channels in IDLE; red_o all ones; green_o, done_o and busy_o all zero; prescaler and phase counters zero.
- Prescaler: counts 0..TICKS_PER_SEC-1 and wraps.
  - sec_tick fires at count TICKS_PER_SEC-1.
  - half_tick fires at counts TICKS_PER_SEC/2-1 and TICKS_PER_SEC-1.
  - One prescaler is shared by all channels and is never restarted by a channel.
- Per-channel states:
  - IDLE: red. start_i=1 -> DELAY, or -> GREEN if DELAY_S=0.
  - DELAY: red; lasts DELAY_S sec_ticks -> GREEN.
  - GREEN: green; lasts GREEN_S sec_ticks -> BLINK.
  - BLINK: red off; green on at entry, toggles on every half_tick; lasts BLINK_S sec_ticks -> DONE.
  - DONE: red; done_o=1 for exactly this one cycle -> IDLE.
  - MAINT: green and red both off.
- Phase counter:
  - Cleared on state entry; increments on sec_tick.
  - The state exits on the sec_tick where the count equals duration-1.
  - Wall time in a state is therefore between (S-1)*TICKS_PER_SEC+1 and S*TICKS_PER_SEC cycles.
- Outputs are a Moore decode of the registered state, with no extra latency.
- Boundary rules:
  - start_i while a channel is not in IDLE is ignored, not queued.
  - A held start_i re-triggers on return to IDLE.
  - maint_i=1 sends every channel to MAINT on the next edge from any state, with no done_o. Priority is maint_i over start_i.
  - maint_i falling returns channels to IDLE on the next edge, with counters cleared.
  - A sec_tick coinciding with a half_tick toggles first, then exits.
  - Reset asserted mid-phase forces IDLE outputs immediately.

## Timing
- start_i sampled at edge k -> state DELAY (or GREEN) visible after edge k; busy_o rises the same cycle.
- done_o is high the cycle before busy_o falls.
- Channels are fully independent; simultaneous starts run in lockstep.

## Configuration
- PED_COUNTDOWN_EN defined: adds output remain_o (N_CH*CW).
  - Per channel, it carries the seconds remaining in GREEN or BLINK (duration minus phase count).
  - It is 0 in all other states; reset value 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

## Structure
- Package ped_pkg holds:
  - the state enum (IDLE, DELAY, GREEN, BLINK, DONE, MAINT);
  - the default timing localparams;
  - a function for counter width.
- Sub-module ped_tick_gen: the prescaler, emitting sec_tick and half_tick. Instantiated once; per-channel FSMs are built with a generate loop.

## Test plan
Bench settings: TICKS_PER_SEC=10, N_CH=2, DELAY_S=1, GREEN_S=3, BLINK_S=2. Reset is released before edge 0; sec_tick falls at cycles 9, 19, 29, …
- Nominal: start_i[0] pulse at cycle 2 -> DELAY 3..9, GREEN 10..39, BLINK 40..59, done_o[0]=1 at cycle 60, IDLE from 61. Channel 1 stays red throughout.
- Blink pattern: in the nominal case, green_o[0]=1 for 40..44, 0 for 45..49, 1 for 50..54, 0 for 55..59; red_o[0]=0 throughout.
- Ignored start: start_i[0] pulse at cycle 25 during GREEN -> no change to the timeline and no second done_o.
- Maintenance: maint_i=1 at cycle 30 during GREEN -> cycle 31 onward green_o=red_o=0 on both channels, no done_o. maint_i=0 at 50 -> red_o=1 from 51.
- Reset mid-phase: reset low at cycle 45 -> red_o=all ones, green_o=0, busy_o=0 immediately. After release, a restart reproduces the nominal timeline.
- DELAY_S=0 with a start at cycle 2 -> GREEN from cycle 3; with PED_COUNTDOWN_EN, remain_o[0] reads 3, 2, 1 across the GREEN seconds.

Source files
------------

// File: rtl/ped_pkg.sv
// ped_pkg: shared types, default timing and helpers for the pedestrian crossing controller.
// Contents:
//   ped_state_t           per-channel phase (IDLE, DELAY, GREEN, BLINK, DONE, MAINT)
//   PED_*                 default timing parameters
//   ped_width(max_val)    bits needed to hold values 0..max_val
package ped_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DELAY,
        GREEN,
        BLINK,
        DONE,
        MAINT
    } ped_state_t;

    localparam int PED_TICKS_PER_SEC = 10_000_000;
    localparam int PED_N_CH          = 2;
    localparam int PED_DELAY_S       = 1;
    localparam int PED_GREEN_S       = 12;
    localparam int PED_BLINK_S       = 6;
    localparam int PED_CW            = 8;

    function automatic int ped_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/ped_tick_gen.sv
// ped_tick_gen: shared seconds prescaler; counts 0..TICKS_PER_SEC-1 and wraps.
// Ports:
//   clk        in   clock
//   reset      in   asynchronous, active-low
//   sec_tick   out  high during count TICKS_PER_SEC-1
//   half_tick  out  high during counts TICKS_PER_SEC/2-1 and TICKS_PER_SEC-1
module ped_tick_gen
    import ped_pkg::*;
#(
    parameter int TICKS_PER_SEC = PED_TICKS_PER_SEC
) (
    input  logic clk,
    input  logic reset,
    output logic sec_tick,
    output logic half_tick
);

    localparam int             W    = ped_width(TICKS_PER_SEC - 1);
    localparam logic [W-1:0]   LAST = W'(TICKS_PER_SEC - 1);
    localparam logic [W-1:0]   HALF = W'(TICKS_PER_SEC / 2 - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign sec_tick  = (cnt == LAST);
    assign half_tick = sec_tick || (cnt == HALF);

endmodule

// File: rtl/ped_xing_ctrl.sv
// ped_xing_ctrl: multi-channel pedestrian crossing controller.
// Each channel runs IDLE -> [DELAY] -> GREEN -> BLINK -> DONE -> IDLE on a start
// request; maint_i darkens every head. All channels share one seconds prescaler.
// Ports:
//   clk       in   clock
//   reset     in   asynchronous, active-low
//   maint_i   in   maintenance level; overrides every channel
//   start_i   in   [N_CH] per-channel start request (pulse or level)
//   busy_o    out  [N_CH] channel not in IDLE or MAINT
//   done_o    out  [N_CH] one-cycle hand-back pulse
//   green_o   out  [N_CH] pedestrian green lamp
//   red_o     out  [N_CH] pedestrian red lamp
//   remain_o  out  [N_CH*CW] seconds left in GREEN/BLINK, 0 elsewhere
//                  (present only when PED_COUNTDOWN_EN is defined)
module ped_xing_ctrl
    import ped_pkg::*;
#(
    parameter int TICKS_PER_SEC = PED_TICKS_PER_SEC,
    parameter int N_CH          = PED_N_CH,
    parameter int DELAY_S       = PED_DELAY_S,
    parameter int GREEN_S       = PED_GREEN_S,
    parameter int BLINK_S       = PED_BLINK_S,
    parameter int CW            = PED_CW
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               maint_i,
    input  logic [N_CH-1:0]    start_i,
    output logic [N_CH-1:0]    busy_o,
    output logic [N_CH-1:0]    done_o,
    output logic [N_CH-1:0]    green_o,
`ifdef PED_COUNTDOWN_EN
    output logic [N_CH-1:0]    red_o,
    output logic [N_CH*CW-1:0] remain_o
`else
    output logic [N_CH-1:0]    red_o
`endif
);

    // Phase counter value on the sec_tick that ends each timed phase.
    localparam logic [CW-1:0] DELAY_LAST = CW'((DELAY_S > 0) ? DELAY_S - 1 : 0);
    localparam logic [CW-1:0] GREEN_LAST = CW'(GREEN_S - 1);
    localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_S - 1);

    logic sec_tick;
    logic half_tick;

    ped_tick_gen #(
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_tick (
        .clk      (clk),
        .reset    (reset),
        .sec_tick (sec_tick),
        .half_tick(half_tick)
    );

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        ped_state_t    state_q;
        ped_state_t    state_d;
        logic [CW-1:0] cnt_q;
        logic [CW-1:0] cnt_d;
        logic          blink_q;
        logic          blink_d;
        logic          phase_end;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                blink_q <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                blink_q <= blink_d;
            end
        end

        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            blink_d   = blink_q;
            phase_end = sec_tick && (cnt_q == ((state_q == DELAY) ? DELAY_LAST :
                                               (state_q == GREEN) ? GREEN_LAST : BLINK_LAST));
            if (maint_i) begin
                state_d = MAINT;
            end else begin
                case (state_q)
                    IDLE:    if (start_i[c]) state_d = (DELAY_S == 0) ? GREEN : DELAY;
                    DELAY:   if (phase_end) state_d = GREEN;
                    GREEN:   if (phase_end) state_d = BLINK;
                    BLINK:   if (phase_end) state_d = DONE;
                    DONE:    state_d = IDLE;
                    MAINT:   state_d = IDLE;
                    default: state_d = IDLE;
                endcase
            end
            // Counter only runs inside a timed phase and restarts on every entry.
            if (state_d != state_q || state_d inside {IDLE, DONE, MAINT}) begin
                cnt_d = '0;
            end else if (sec_tick) begin
                cnt_d = cnt_q + 1'b1;
            end
            // Blink starts lit; a half_tick that also ends BLINK is irrelevant since we leave.
            if (state_d == BLINK) begin
                blink_d = (state_q != BLINK) ? 1'b1 : (blink_q ^ half_tick);
            end
        end

        assign busy_o[c]  = !(state_q inside {IDLE, MAINT});
        assign done_o[c]  = (state_q == DONE);
        assign green_o[c] = (state_q == GREEN) || ((state_q == BLINK) && blink_q);
        assign red_o[c]   = state_q inside {IDLE, DELAY, DONE};

`ifdef PED_COUNTDOWN_EN
        assign remain_o[c*CW +: CW] = (state_q == GREEN) ? CW'(GREEN_S) - cnt_q :
                                      (state_q == BLINK) ? CW'(BLINK_S) - cnt_q : '0;
`endif
    end

endmodule
